jk_counter_bank: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register built from per-bit JK cells.
- Operating modes: per-bit JK, count up, count down and parallel load.
- Supports a programmable modulus, wrap or saturate at the limits, a terminal-count flag and a registered event pulse.
- Used as the general counter/register primitive in the counter datapaths (modulo-N counters, decade counters, bit-set/clear registers).

---
 rtl/jk_counter_bank.sv | 166 ++++++++++++++++
 tb/tb_jk_counter_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : jk_counter_bank
// Description : WIDTH-bit register built from per-bit JK cells. Four modes:
//               per-bit JK, count up, count down and parallel load. Programmable
//               modulus (MAX_COUNT), wrap or saturate at the limits,
//               combinational terminal-count flag and registered event pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1      rising-edge clock
//   async_reset_n  in   1      asynchronous active-low reset
//   sync_reset     in   1      synchronous clear, active-high
//   en             in   1      operation enable (0 = hold)
//   mode           in   2      00 JK, 01 up, 10 down, 11 load
//   J, K           in   WIDTH  per-bit JK controls (JK mode)
//   load_val       in   WIDTH  parallel load value (load mode)
//   Q              out  WIDTH  register state, never above MAX_COUNT
//   tc             out  1      terminal count (cycle before wrap/saturate)
//   event_pulse    out  1      one-cycle pulse after a wrap/saturate/clamp
// ============================================================================
module jk_counter_bank #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (2 ** WIDTH) - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             sync_reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             event_pulse
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] MAX_Q  = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             event_q;
  logic             event_d;

  // Raw per-bit JK result before the modulus clamp.
  logic [WIDTH-1:0] jk_result;

  // Limit detection shared by next-state and tc. ">=" rather than "==" so a
  // corrupted state above the modulus still heads back into range.
  logic at_max;
  logic at_zero;

  assign at_max  = (q_q >= MAX_Q);
  assign at_zero = (q_q == ZERO_Q);

  // --------------------------------------------------------------------------
  // Per-bit JK cells: Q+ = J & ~Q | ~K & Q  (00 hold, 01 clear, 10 set,
  // 11 toggle).
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign jk_result[i] = (J[i] & ~q_q[i]) | (~K[i] & q_q[i]);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    q_d     = q_q;
    event_d = 1'b0;

    if (sync_reset) begin
      // Clear wins over everything, including any wrap that would have
      // happened on this edge.
      q_d     = ZERO_Q;
      event_d = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_JK: begin
          if (jk_result > MAX_Q) begin
            q_d     = MAX_Q;
            event_d = 1'b1;
          end else begin
            q_d = jk_result;
          end
        end

        MODE_UP: begin
          if (at_max) begin
            q_d     = SATURATE ? MAX_Q : ZERO_Q;
            event_d = 1'b1;
          end else begin
            q_d = q_q + ONE_Q;
          end
        end

        MODE_DOWN: begin
          if (at_zero) begin
            q_d     = SATURATE ? ZERO_Q : MAX_Q;
            event_d = 1'b1;
          end else if (q_q > MAX_Q) begin
            // Out-of-range state cannot arise normally; pull it to the limit.
            q_d = MAX_Q;
          end else begin
            q_d = q_q - ONE_Q;
          end
        end

        MODE_LOAD: begin
          if (load_val > MAX_Q) begin
            q_d     = MAX_Q;
            event_d = 1'b1;
          end else begin
            q_d = load_val;
          end
        end

        default: begin
          q_d     = q_q;
          event_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      q_q     <= ZERO_Q;
      event_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      event_q <= event_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Q           = q_q;
  assign event_pulse = event_q;

  // Terminal count looks only at the counting modes; JK/load clamps are
  // reported solely through event_pulse.
  assign tc = en & ~sync_reset &
              (((mode == MODE_UP) & (q_q == MAX_Q)) |
               ((mode == MODE_DOWN) & at_zero));

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_counter_bank
// Description : Directed self-checking bench for jk_counter_bank. Two
//               instances (WIDTH=4, MAX_COUNT=9) share all inputs: one wraps,
//               one saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_bank;

  logic       clk;
  logic       async_reset_n;
  logic       sync_reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] J;
  logic [3:0] K;
  logic [3:0] load_val;

  logic [3:0] q_w;
  logic       tc_w;
  logic       ev_w;
  logic [3:0] q_s;
  logic       tc_s;
  logic       ev_s;

  int vec_cnt;
  int err_cnt;

  jk_counter_bank #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_wrap (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .sync_reset    (sync_reset),
    .en            (en),
    .mode          (mode),
    .J             (J),
    .K             (K),
    .load_val      (load_val),
    .Q             (q_w),
    .tc            (tc_w),
    .event_pulse   (ev_w)
  );

  jk_counter_bank #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_sat (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .sync_reset    (sync_reset),
    .en            (en),
    .mode          (mode),
    .J             (J),
    .K             (K),
    .load_val      (load_val),
    .Q             (q_s),
    .tc            (tc_s),
    .event_pulse   (ev_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0; sync_reset = 1'b0; en = 1'b0;
    mode = 2'b00; J = '0; K = '0; load_val = '0;
    #2;
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL reset_init: Q=%0d ev=%0b, want Q=0 ev=0", q_w, ev_w);
    end
    step();
    async_reset_n = 1'b1;
    en = 1'b1; mode = 2'b11; load_val = 4'd5;
    step();
    vec_cnt++;
    if (q_w !== 4'd5) begin
      err_cnt++; $display("FAIL reset_preload: Q=%0d, want 5", q_w);
    end
    // Pulse reset between edges.
    mode = 2'b01;
    #2;
    async_reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL reset_async: Q=%0d ev=%0b, want Q=0 ev=0", q_w, ev_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd0) begin
      err_cnt++; $display("FAIL reset_hold_edge: Q=%0d, want 0", q_w);
    end
    async_reset_n = 1'b1;
    step();
    vec_cnt++;
    if (q_w !== 4'd1) begin
      err_cnt++; $display("FAIL reset_release_1: Q=%0d, want 1", q_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd2) begin
      err_cnt++; $display("FAIL reset_release_2: Q=%0d, want 2", q_w);
    end
  endtask

  task automatic test_up_wrap();
    sync_reset = 1'b1; en = 1'b1; mode = 2'b01;
    step();
    sync_reset = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      vec_cnt++;
      if (q_w !== 4'(i) || tc_w !== (i == 9) || ev_w !== 1'b0) begin
        err_cnt++;
        $display("FAIL up_count[%0d]: Q=%0d tc=%0b ev=%0b, want Q=%0d tc=%0b ev=0",
                 i, q_w, tc_w, ev_w, i, (i == 9));
      end
      step();
    end
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b1 || tc_w !== 1'b0) begin
      err_cnt++; $display("FAIL up_wrap: Q=%0d ev=%0b tc=%0b, want Q=0 ev=1 tc=0", q_w, ev_w, tc_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd1 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL up_after_wrap: Q=%0d ev=%0b, want Q=1 ev=0", q_w, ev_w);
    end
  endtask

  task automatic test_down_saturate();
    logic [3:0] exp_w [5];
    logic [3:0] exp_s [5];
    logic       exp_ev [5];
    exp_w  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    exp_s  = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    exp_ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    en = 1'b1; mode = 2'b11; load_val = 4'd2;
    step();
    mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (q_s !== exp_s[i] || ev_s !== exp_ev[i] || tc_s !== (exp_s[i] == 4'd0)) begin
        err_cnt++;
        $display("FAIL down_sat[%0d]: Q=%0d ev=%0b tc=%0b, want Q=%0d ev=%0b tc=%0b",
                 i, q_s, ev_s, tc_s, exp_s[i], exp_ev[i], (exp_s[i] == 4'd0));
      end
      vec_cnt++;
      if (q_w !== exp_w[i]) begin
        err_cnt++; $display("FAIL down_wrap[%0d]: Q=%0d, want %0d", i, q_w, exp_w[i]);
      end
      step();
    end
  endtask

  task automatic test_jk();
    en = 1'b1; mode = 2'b11; load_val = 4'b0101;
    step();
    mode = 2'b00; J = 4'b0010; K = 4'b0001;
    #1;
    vec_cnt++;
    if (tc_w !== 1'b0) begin
      err_cnt++; $display("FAIL jk_tc: tc=%0b, want 0", tc_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'b0110 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL jk_set_clear: Q=%b ev=%0b, want Q=0110 ev=0", q_w, ev_w);
    end
    J = 4'b1111; K = 4'b1111;
    step();
    vec_cnt++;
    if (q_w !== 4'd9 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL jk_toggle: Q=%0d ev=%0b, want Q=9 ev=0", q_w, ev_w);
    end
    J = 4'b0110; K = 4'b0000;
    step();
    vec_cnt++;
    if (q_w !== 4'd9 || ev_w !== 1'b1) begin
      err_cnt++; $display("FAIL jk_clamp: Q=%0d ev=%0b, want Q=9 ev=1", q_w, ev_w);
    end
    J = '0; K = '0;
  endtask

  task automatic test_load_priority();
    en = 1'b1; mode = 2'b11; load_val = 4'd7;
    step();
    vec_cnt++;
    if (q_w !== 4'd7 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL load_7: Q=%0d ev=%0b, want Q=7 ev=0", q_w, ev_w);
    end
    load_val = 4'd12;
    step();
    vec_cnt++;
    if (q_w !== 4'd9 || ev_w !== 1'b1) begin
      err_cnt++; $display("FAIL load_clamp: Q=%0d ev=%0b, want Q=9 ev=1", q_w, ev_w);
    end
    sync_reset = 1'b1; load_val = 4'd3;
    step();
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL sync_over_load: Q=%0d ev=%0b, want Q=0 ev=0", q_w, ev_w);
    end
    sync_reset = 1'b0; load_val = 4'd9;
    step();
    mode = 2'b01;
    #1;
    vec_cnt++;
    if (tc_w !== 1'b1) begin
      err_cnt++; $display("FAIL tc_at_max: tc=%0b, want 1", tc_w);
    end
    en = 1'b0;
    #1;
    vec_cnt++;
    if (tc_w !== 1'b0) begin
      err_cnt++; $display("FAIL tc_en_low: tc=%0b, want 0", tc_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd9 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL en_hold: Q=%0d ev=%0b, want Q=9 ev=0", q_w, ev_w);
    end
    // Sync reset on a would-be wrap edge: no tc, no event.
    en = 1'b1; sync_reset = 1'b1;
    #1;
    vec_cnt++;
    if (tc_w !== 1'b0) begin
      err_cnt++; $display("FAIL tc_sync_reset: tc=%0b, want 0", tc_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL sync_suppress_wrap: Q=%0d ev=%0b, want Q=0 ev=0", q_w, ev_w);
    end
    sync_reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 2'b01;
    step();
    vec_cnt++;
    if (q_w !== 4'd1) begin
      err_cnt++; $display("FAIL b2b_up: Q=%0d, want 1", q_w);
    end
    mode = 2'b10;
    step();
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b0) begin
      err_cnt++; $display("FAIL b2b_down: Q=%0d ev=%0b, want Q=0 ev=0", q_w, ev_w);
    end
    step();
    vec_cnt++;
    if (q_w !== 4'd9 || ev_w !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_down_wrap: Q=%0d ev=%0b, want Q=9 ev=1", q_w, ev_w);
    end
    mode = 2'b01;
    step();
    vec_cnt++;
    if (q_w !== 4'd0 || ev_w !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_up_wrap: Q=%0d ev=%0b, want Q=0 ev=1", q_w, ev_w);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_up_wrap();
    test_down_saturate();
    test_jk();
    test_load_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
